// File: rtl/lane_tx_serializer.sv
// lane_tx_serializer
//   Transmit-side consumer of the 128-bit logphy data queue. Pops one word
//   per ready/valid handshake and serializes it into BEATS = 128/W lane beats
//   (W = NUM_LANES*LANE_BITS), one beat per cycle with tx_en_i high. Beat 0
//   carries the word LSBs. Back-to-back words are streamed with no bubble.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   deq_valid_i     queue head word available
//   deq_rdy_o       word accepted this cycle (from state/tx_en_i only)
//   data_i[127:0]   queue head word
//   tx_en_i         lane clock enable; low stalls beat advance
//   lane_data_o[W]  current beat; lane j = bits [j*LANE_BITS +: LANE_BITS]
//   lane_valid_o    lane_data_o carries a beat
//   words_sent_o    fully transmitted word count, wraps at 2^16
//   parity_o        (LANE_TX_PARITY_EN only) XOR of lane_data_o
//
// Optional feature macro: LANE_TX_PARITY_EN adds parity_o.
module lane_tx_serializer #(
  parameter int NUM_LANES = 16,
  parameter int LANE_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          deq_valid_i,
  output logic                          deq_rdy_o,
  input  logic [127:0]                  data_i,
  input  logic                          tx_en_i,
  output logic [NUM_LANES*LANE_BITS-1:0] lane_data_o,
  output logic                          lane_valid_o,
`ifdef LANE_TX_PARITY_EN
  output logic                          parity_o,
`endif
  output logic [15:0]                   words_sent_o
);

  localparam int W     = NUM_LANES * LANE_BITS;
  localparam int BEATS = 128 / W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  if ((128 % W) != 0) begin : g_bad_width
    $error("lane_tx_serializer: NUM_LANES*LANE_BITS must divide 128");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [127:0]    r_word;
  logic [15:0]     r_words_sent;
  logic            w_rdy, w_load, w_done;

  // Next-state logic. Ready depends only on state, beat position and tx_en_i
  // so the queue can present valid as a function of ready without a loop.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rdy          = 1'b0;
    w_load         = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (deq_valid_i) begin
          w_load         = 1'b1;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (tx_en_i) begin
          if (r_beat_cnt == LAST) begin
            w_done         = 1'b1;
            w_rdy          = 1'b1;
            w_beat_cnt_nxt = '0;
            if (deq_valid_i) w_load = 1'b1;
            else             w_state_nxt = IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Nothing is accepted while held in reset.
    if (reset) begin
      w_rdy  = 1'b0;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_word       <= '0;
      r_words_sent <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_load) r_word <= data_i;
      if (w_done) r_words_sent <= r_words_sent + 16'd1;
    end
  end

  assign deq_rdy_o    = w_rdy;
  assign lane_valid_o = (r_state == SEND);
  assign lane_data_o  = (r_state == SEND) ? r_word[int'(r_beat_cnt)*W +: W] : '0;
  assign words_sent_o = r_words_sent;

`ifdef LANE_TX_PARITY_EN
  // lane_data_o is already 0 in IDLE, so parity is 0 there as well.
  assign parity_o = ^lane_data_o;
`endif

endmodule

// File: tb/tb_lane_tx_serializer.sv
module tb_lane_tx_serializer;

  logic         clk = 1'b0;
  logic         reset;
  // dut0: 16 lanes x 2 bits, W=32, BEATS=4
  logic         deq_valid, deq_rdy, tx_en, lane_valid;
  logic [127:0] data;
  logic [31:0]  lane_data;
  logic [15:0]  words_sent;
  // dut1: 64 lanes x 2 bits, W=128, BEATS=1 (one word per cycle)
  logic         d1_valid, d1_rdy, d1_tx_en, d1_lane_valid;
  logic [127:0] d1_data, d1_lane_data;
  logic [15:0]  d1_words;
`ifdef LANE_TX_PARITY_EN
  logic         parity, d1_parity;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] W0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] WA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] WB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] WC = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

  always #5 clk = ~clk;

  lane_tx_serializer #(.NUM_LANES(16), .LANE_BITS(2)) dut0 (
    .clk(clk), .reset(reset), .deq_valid_i(deq_valid), .deq_rdy_o(deq_rdy),
    .data_i(data), .tx_en_i(tx_en), .lane_data_o(lane_data),
    .lane_valid_o(lane_valid),
`ifdef LANE_TX_PARITY_EN
    .parity_o(parity),
`endif
    .words_sent_o(words_sent)
  );

  lane_tx_serializer #(.NUM_LANES(64), .LANE_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .deq_valid_i(d1_valid), .deq_rdy_o(d1_rdy),
    .data_i(d1_data), .tx_en_i(d1_tx_en), .lane_data_o(d1_lane_data),
    .lane_valid_o(d1_lane_valid),
`ifdef LANE_TX_PARITY_EN
    .parity_o(d1_parity),
`endif
    .words_sent_o(d1_words)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; deq_valid = 1'b0; tx_en = 1'b1; data = '0;
    d1_valid = 1'b0; d1_tx_en = 1'b1; d1_data = '0;
    step(); step();
    reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; deq_valid = 1'b1; tx_en = 1'b1; data = W0;
    d1_valid = 1'b0; d1_tx_en = 1'b1; d1_data = '0;
    step();
    checks++; if (lane_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", lane_valid); end
    checks++; if (lane_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", lane_data); end
    checks++; if (words_sent !== 16'h0) begin failures++; $display("FAIL rst_words got=%h exp=0", words_sent); end
    checks++; if (deq_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy_in_reset got=%b exp=0", deq_rdy); end
    deq_valid = 1'b0; reset = 1'b0; #1;
    checks++; if (deq_rdy !== 1'b1) begin failures++; $display("FAIL rst_rdy_idle got=%b exp=1", deq_rdy); end
  endtask

  task automatic test_single_word();
    logic [127:0] w;
    do_reset();
    w = W0;
    deq_valid = 1'b1; data = w; step(); deq_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (lane_data !== w[k*32 +: 32] || lane_valid !== 1'b1) begin
        failures++; $display("FAIL single_beat%0d got=%h/%b exp=%h/1", k, lane_data, lane_valid, w[k*32 +: 32]);
      end
      checks++; if (deq_rdy !== (k == 3)) begin failures++; $display("FAIL single_rdy%0d got=%b exp=%b", k, deq_rdy, k == 3); end
      step();
    end
    checks++; if (lane_valid !== 1'b0 || lane_data !== 32'h0) begin
      failures++; $display("FAIL single_idle got=%h/%b exp=0/0", lane_data, lane_valid);
    end
    checks++; if (words_sent !== 16'd1) begin failures++; $display("FAIL single_words got=%0d exp=1", words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ws [3];
    logic [127:0] w;
    ws[0] = WA; ws[1] = WB; ws[2] = WC;
    do_reset();
    deq_valid = 1'b1; data = ws[0]; step();
    for (int i = 0; i < 3; i++) begin
      w = ws[i];
      for (int k = 0; k < 4; k++) begin
        checks++; if (lane_data !== w[k*32 +: 32] || lane_valid !== 1'b1) begin
          failures++; $display("FAIL b2b_w%0d_beat%0d got=%h/%b exp=%h/1", i, k, lane_data, lane_valid, w[k*32 +: 32]);
        end
        checks++; if (deq_rdy !== (k == 3)) begin failures++; $display("FAIL b2b_rdy_w%0d_b%0d got=%b exp=%b", i, k, deq_rdy, k == 3); end
        if (k == 3) begin
          if (i < 2) data = ws[i+1];
          else deq_valid = 1'b0;
        end
        step();
      end
    end
    checks++; if (lane_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", lane_valid); end
    checks++; if (words_sent !== 16'd3) begin failures++; $display("FAIL b2b_words got=%0d exp=3", words_sent); end
  endtask

  task automatic test_stall();
    logic [127:0] w;
    do_reset();
    w = W0;
    deq_valid = 1'b1; data = w; step(); deq_valid = 1'b0;
    step();                       // now presenting beat 1
    tx_en = 1'b0; #1;
    checks++; if (deq_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy got=%b exp=0", deq_rdy); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (lane_data !== 32'h07060504 || lane_valid !== 1'b1 || words_sent !== 16'd0 || deq_rdy !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%b/%0d/%b exp=07060504/1/0/0", c, lane_data, lane_valid, words_sent, deq_rdy);
      end
    end
    tx_en = 1'b1; #1;
    for (int k = 1; k < 4; k++) begin
      checks++; if (lane_data !== w[k*32 +: 32]) begin failures++; $display("FAIL stall_resume%0d got=%h exp=%h", k, lane_data, w[k*32 +: 32]); end
      step();
    end
    checks++; if (words_sent !== 16'd1 || lane_valid !== 1'b0) begin
      failures++; $display("FAIL stall_done got=%0d/%b exp=1/0", words_sent, lane_valid);
    end
    // IDLE accepts with tx_en_i low; beat 0 waits for the enable.
    tx_en = 1'b0; deq_valid = 1'b1; data = WA; #1;
    checks++; if (deq_rdy !== 1'b1) begin failures++; $display("FAIL idle_rdy_noen got=%b exp=1", deq_rdy); end
    step(); deq_valid = 1'b0; step(); step();
    checks++; if (lane_data !== 32'hA0A0A0A0 || lane_valid !== 1'b1) begin
      failures++; $display("FAIL idle_noen_hold got=%h/%b exp=a0a0a0a0/1", lane_data, lane_valid);
    end
    tx_en = 1'b1; step();
    checks++; if (lane_data !== 32'hA1A1A1A1) begin failures++; $display("FAIL idle_noen_adv got=%h exp=a1a1a1a1", lane_data); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    deq_valid = 1'b1; data = W0; step(); deq_valid = 1'b0;
    step(); step();
    checks++; if (lane_data !== 32'h0B0A0908) begin failures++; $display("FAIL midrst_beat2 got=%h exp=0b0a0908", lane_data); end
    reset = 1'b1; step();
    checks++; if (lane_valid !== 1'b0 || lane_data !== 32'h0 || words_sent !== 16'h0) begin
      failures++; $display("FAIL midrst_clear got=%h/%b/%0d exp=0/0/0", lane_data, lane_valid, words_sent);
    end
    reset = 1'b0; #1;
    checks++; if (deq_rdy !== 1'b1) begin failures++; $display("FAIL midrst_rdy got=%b exp=1", deq_rdy); end
    step(); step();
    checks++; if (lane_valid !== 1'b0 || words_sent !== 16'h0) begin
      failures++; $display("FAIL midrst_no_beats got=%b/%0d exp=0/0", lane_valid, words_sent);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    d1_valid = 1'b1; d1_data = 128'h1; step();
    checks++; if (d1_lane_valid !== 1'b1 || d1_rdy !== 1'b1 || d1_lane_data !== 128'h1) begin
      failures++; $display("FAIL b1_stream got=%h/%b/%b exp=1/1/1", d1_lane_data, d1_lane_valid, d1_rdy);
    end
    for (int i = 0; i < 65535; i++) begin
      d1_data = 128'(i + 2);
      step();
    end
    checks++; if (d1_words !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", d1_words); end
    checks++; if (d1_lane_data !== 128'd65536) begin failures++; $display("FAIL b1_data got=%h exp=10000", d1_lane_data); end
    d1_valid = 1'b0; step();
    checks++; if (d1_words !== 16'h0000 || d1_lane_valid !== 1'b0) begin
      failures++; $display("FAIL wrap got=%h/%b exp=0000/0", d1_words, d1_lane_valid);
    end
  endtask

`ifdef LANE_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    checks++; if (parity !== 1'b0) begin failures++; $display("FAIL par_idle got=%b exp=0", parity); end
    deq_valid = 1'b1; data = {64'h0, 32'h3, 32'h1}; step(); deq_valid = 1'b0;
    checks++; if (parity !== 1'b1) begin failures++; $display("FAIL par_beat1 got=%b exp=1", parity); end
    step();
    checks++; if (parity !== 1'b0) begin failures++; $display("FAIL par_beat3 got=%b exp=0", parity); end
    step(); step(); step();
    checks++; if (parity !== 1'b0 || lane_valid !== 1'b0) begin failures++; $display("FAIL par_after got=%b exp=0", parity); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_wrap();
`ifdef LANE_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
